// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, word type, arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker.
// Prefers ptr when it requests, otherwise the other side.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant
);

  assign grant = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/memory_arbiter.sv
// RAM port arbiter: data first, round-robin icache,
// starvation counter forces instruction progress.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ISTARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            dREN,
  input  logic            dWEN,
  input  word_t           daddr,
  input  word_t           dstore,
  output logic            dwait,
  output word_t           dload,
  input  logic [1:0]      iREN,
  input  word_t [1:0]     iaddr,
  output logic [1:0]      iwait,
  output word_t [1:0]     iload,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  localparam int SW = $clog2(ISTARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(ISTARVE_LIMIT);

  arb_state_t    state, stateNext;
  logic          ipick, ipickNext;
  logic          icur, icurNext;
  logic [SW-1:0] starve, starveNext;

  logic dReq, iAny, done, pick;
  logic starveHit, dGo, iGo;

  assign dReq = dREN | dWEN;
  assign iAny = |iREN;
  assign done = (ramstate == ACCESS);

  assign starveHit = (starve == LIM) && iAny;
  assign dGo = !starveHit && dReq;
  assign iGo = !starveHit && !dReq && iAny;

  rr_pick2 uPick (
    .req   (iREN),
    .ptr   (ipick),
    .grant (pick)
  );

  always_comb begin
    stateNext  = state;
    ipickNext  = ipick;
    icurNext   = icur;
    starveNext = starve;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          starveHit, iGo: begin
            stateNext = IGRANT;
            icurNext  = pick;
          end
          dGo: stateNext = DGRANT;
          default: stateNext = IDLE;
        endcase
      end
      DGRANT: begin
        if (!dReq) begin
          stateNext = IDLE;
        end else if (done) begin
          stateNext = IDLE;
          if (!iAny)
            starveNext = '0;
          else if (starve != LIM)
            starveNext = starve + SW'(1);
        end
      end
      IGRANT: begin
        if (!iREN[icur]) begin
          stateNext = IDLE;
        end else if (done) begin
          stateNext  = IDLE;
          ipickNext  = ~icur;
          starveNext = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    dwait    = 1'b1;
    dload    = '0;
    iwait    = 2'b11;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      DGRANT: begin
        if (dReq) begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (done) begin
            dwait = 1'b0;
            dload = ramload;
          end
        end
      end
      IGRANT: begin
        if (iREN[icur]) begin
          ramREN  = 1'b1;
          ramaddr = iaddr[icur];
          if (done) begin
            iwait[icur] = 1'b0;
            iload[icur] = ramload;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      ipick  <= 1'b0;
      icur   <= 1'b0;
      starve <= '0;
    end else begin
      state  <= stateNext;
      ipick  <= ipickNext;
      icur   <= icurNext;
      starve <= starveNext;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        dREN, dWEN;
  word_t       daddr, dstore;
  logic        dwait;
  word_t       dload;
  logic [1:0]  iREN;
  word_t [1:0] iaddr;
  logic [1:0]  iwait;
  word_t [1:0] iload;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  int vectors = 0;
  int errs = 0;

  memory_arbiter #(.ISTARVE_LIMIT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_dwait"}, dwait, 1);
    chk({tag, "_iwait"}, iwait, 2'b11);
    chk({tag, "_dload"}, dload, 0);
    chk({tag, "_iload0"}, iload[0], 0);
    chk({tag, "_iload1"}, iload[1], 0);
    chk({tag, "_ramREN"}, ramREN, 0);
    chk({tag, "_ramWEN"}, ramWEN, 0);
    chk({tag, "_ramaddr"}, ramaddr, 0);
    chk({tag, "_ramstore"}, ramstore, 0);
  endtask

  initial begin
    nRST = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    iREN = 0; iaddr = '0; ramload = 0; ramstate = FREE;
    #12;
    chkReset("rst");
    @(posedge CLK); #1 nRST = 1;
    tick();

    // single data read with two BUSY cycles
    dREN = 1; daddr = 32'h40; #2;
    chk("t1_idle_ren", ramREN, 0);
    tick(); ramstate = BUSY; #2;
    chk("t1_b1_ren", ramREN, 1);
    chk("t1_b1_addr", ramaddr, 32'h40);
    chk("t1_b1_dwait", dwait, 1);
    tick(); #2;
    chk("t1_b2_dwait", dwait, 1);
    chk("t1_b2_ren", ramREN, 1);
    tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #2;
    chk("t1_acc_dwait", dwait, 0);
    chk("t1_acc_dload", dload, 32'hDEADBEEF);
    chk("t1_acc_iwait", iwait, 2'b11);
    tick(); dREN = 0; ramstate = FREE; #2;
    chk("t1_bub_dwait", dwait, 1);
    chk("t1_bub_ren", ramREN, 0);

    // data write beats simultaneous instruction request
    dWEN = 1; dstore = 32'h12345678; daddr = 32'h80; iREN = 2'b01;
    iaddr[0] = 32'h300; iaddr[1] = 32'h400;
    ramstate = ACCESS; ramload = 32'hCAFE0000; #2;
    chk("t2_idle_wen", ramWEN, 0);
    tick(); #2;
    chk("t2_d_wen", ramWEN, 1);
    chk("t2_d_ren", ramREN, 0);
    chk("t2_d_store", ramstore, 32'h12345678);
    chk("t2_d_addr", ramaddr, 32'h80);
    chk("t2_d_dwait", dwait, 0);
    chk("t2_d_iwait", iwait, 2'b11);
    tick(); dWEN = 0; #2;
    chk("t2_bub_ren", ramREN, 0);
    chk("t2_bub_wen", ramWEN, 0);
    tick(); #2;
    chk("t2_i_ren", ramREN, 1);
    chk("t2_i_addr", ramaddr, 32'h300);
    chk("t2_i_iwait", iwait, 2'b10);
    chk("t2_i_iload0", iload[0], 32'hCAFE0000);
    chk("t2_i_iload1", iload[1], 0);
    chk("t2_i_dwait", dwait, 1);
    tick(); iREN = 0; #2;
    nRST = 0; #2; nRST = 1;
    tick();

    // round robin between both caches
    iREN = 2'b11; iaddr[0] = 32'h200; iaddr[1] = 32'h100;
    ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("t3_idle_ren", ramREN, 0);
      tick(); ramload = 32'hA0 + k; #2;
      chk("t3_iwait", iwait, (k % 2) ? 2'b01 : 2'b10);
      chk("t3_addr", ramaddr, (k % 2) ? 32'h100 : 32'h200);
      chk("t3_iload", iload[k % 2], 32'hA0 + k);
      chk("t3_iload_other", iload[1 - (k % 2)], 0);
      tick();
    end
    iREN = 0;
    tick();

    // starvation: four data completions, then cache 1
    dREN = 1; daddr = 32'h40; iREN = 2'b10; iaddr[1] = 32'h100;
    for (int n = 0; n < 4; n++) begin
      #2;
      chk("t4_idle_ren", ramREN, 0);
      tick(); ramload = n + 1; #2;
      chk("t4_d_dwait", dwait, 0);
      chk("t4_d_dload", dload, n + 1);
      chk("t4_d_iwait", iwait, 2'b11);
      tick();
    end
    #2;
    chk("t4_idle5_ren", ramREN, 0);
    tick(); ramload = 32'h55; #2;
    chk("t4_i_iwait", iwait, 2'b01);
    chk("t4_i_addr", ramaddr, 32'h100);
    chk("t4_i_dwait", dwait, 1);
    chk("t4_i_iload1", iload[1], 32'h55);
    tick(); #2;
    chk("t4_idle6_ren", ramREN, 0);
    tick(); iREN = 0; #2;
    chk("t4_resume_dwait", dwait, 0);
    chk("t4_resume_addr", ramaddr, 32'h40);
    tick(); dREN = 0;
    tick();

    // withdrawal during BUSY
    dREN = 1; daddr = 32'h44; ramstate = BUSY;
    tick(); #2;
    chk("t5_ren", ramREN, 1);
    dREN = 0; #1;
    chk("t5_wd_ren", ramREN, 0);
    chk("t5_wd_dwait", dwait, 1);
    chk("t5_wd_addr", ramaddr, 0);
    tick(); #2;
    chk("t5_after_ren", ramREN, 0);
    chk("t5_after_dwait", dwait, 1);

    // reset in the middle of an instruction grant
    iREN = 2'b01; iaddr[0] = 32'h200; iaddr[1] = 32'h100; ramstate = ACCESS;
    tick(); #2;
    chk("t6_pre_iwait", iwait, 2'b10);
    tick(); iREN = 2'b11; ramstate = BUSY;
    tick(); #2;
    chk("t6_g_addr", ramaddr, 32'h100);
    chk("t6_g_ren", ramREN, 1);
    nRST = 0; #1;
    chkReset("t6_rst");
    @(posedge CLK); #1 nRST = 1; ramstate = ACCESS; #2;
    chk("t6_idle_ren", ramREN, 0);
    tick(); #2;
    chk("t6_first_iwait", iwait, 2'b10);
    chk("t6_first_addr", ramaddr, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
